apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- APB initiator: the requester end of the APB link.
- Accepts single read/write requests on a simple valid/ready request port and runs a compliant APB SETUP/ACCESS transfer for each.
- Returns read data and error status on a one-cycle response strobe.
- Sits between test/processor-side logic and the APB slave bridge, so that bridge can be exercised by real bus traffic.

Parameters:
- DATA_WIDTH, 32, width of write/read data and PWDATA/PRDATA
- ADDR_WIDTH, 32, width of request address and PADDR
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for PREADY before abort; 0 disables timeout

Ports:
- i_clk_apb  in  1  APB clock; all logic on the rising edge
- i_rst_apb  in  1  synchronous reset, active-high
- i_valid  in  1  request valid
- i_rd0_wr1  in  1  request direction: 0 = read, 1 = write
- i_addr  in  ADDR_WIDTH  request address
- i_wr_data  in  DATA_WIDTH  request write data
- o_ready  out  1  bridge can accept a request
- o_resp_valid  out  1  one-cycle response strobe
- o_resp_err  out  1  response error (PSLVERR or timeout); qualified by o_resp_valid
- o_rd_data  out  DATA_WIDTH  read data; qualified by o_resp_valid
- o_psel  out  1  APB PSEL
- o_penable  out  1  APB PENABLE
- o_pwrite  out  1  APB PWRITE
- o_paddr  out  ADDR_WIDTH  APB PADDR
- o_pwdata  out  DATA_WIDTH  APB PWDATA
- i_prdata  in  DATA_WIDTH  APB PRDATA
- i_pready  in  1  APB PREADY
- i_pslverr  in  1  APB PSLVERR

Behaviour:
- Reset (i_rst_apb=1 at clock edge): state IDLE; all outputs 0 except o_ready=1; timeout counter 0.
- Reset mid-transfer: bus deasserted on that edge; no response issued; request is lost.
- FSM states: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE:
  - o_ready=1, o_psel=0, o_penable=0.
  - On i_valid & o_ready: latch addr, wr_data, direction into o_paddr/o_pwdata/o_pwrite; go to SETUP.
- SETUP (exactly one cycle): o_psel=1, o_penable=0, o_ready=0; go to ACCESS.
- ACCESS:
  - o_psel=1, o_penable=1.
  - o_paddr, o_pwrite, o_pwdata held stable from SETUP through the end of ACCESS.
  - i_pready=1: transfer completes; go to IDLE.
    - Next cycle: o_resp_valid=1; o_resp_err=i_pslverr; o_rd_data = i_prdata for reads, 0 for writes.
  - i_pready=0: increment wait counter.
    - If TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES: abort; go to IDLE.
    - Abort response next cycle: o_resp_valid=1, o_resp_err=1, o_rd_data=0.
- i_pslverr and i_prdata are sampled only when i_pready=1 in ACCESS; ignored otherwise.
- Latency: accept at edge N → SETUP N+1 → ACCESS N+2 → (zero wait states) response strobe and o_ready=1 at N+3.
- o_resp_valid is a single-cycle pulse; o_rd_data and o_resp_err hold until the next response.
- A new request may be accepted in the same cycle o_resp_valid is high, because the bridge is in IDLE.
- Idle bus: o_paddr, o_pwdata, o_pwrite keep their last values (no glitching).
- Requests while o_ready=0 are not accepted; the requester must hold i_valid and its payload stable until accepted.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1; cleared on entry to ACCESS.
- At most one outstanding transfer; no pipelining or back-to-back SETUP from ACCESS.

Test Plan:
- Write, zero wait:
  - Stimulus: addr=0x10, data=0xDEADBEEF, i_pready=1 during ACCESS.
  - Response: PSEL=1 from cycle 1, PENABLE=1 in cycle 2 with PWRITE=1, PADDR=0x10; o_resp_valid=1 in cycle 3 with err=0, rd_data=0.
- Read with 3 wait states:
  - Stimulus: addr=0x20; i_pready=0 for 3 ACCESS cycles, then 1 with PRDATA=0x12345678.
  - Response: ACCESS lasts 4 cycles with PADDR stable; o_rd_data=0x12345678, o_resp_valid pulses once.
- Slave error:
  - Stimulus: read with i_pready=1, i_pslverr=1.
  - Response: o_resp_err=1; PSLVERR ignored on a prior cycle where i_pready=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, i_pready held 0.
  - Response: PSEL drops after 4 ACCESS cycles; o_resp_valid=1, o_resp_err=1, o_rd_data=0; o_ready=1.
- Back-to-back:
  - Stimulus: i_valid held high for a write then a read.
  - Response: second request accepted in the cycle of the first response strobe; 3-cycle spacing between SETUPs.
- Reset mid-ACCESS:
  - Stimulus: assert i_rst_apb in the ACCESS cycle.
  - Response: next cycle PSEL=0, PENABLE=0, o_ready=1, no o_resp_valid.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one valid/ready request into an APB SETUP/ACCESS transfer and returns a one-cycle response strobe.
// Latency: accept -> response 3 cycles at zero wait states; o_ready stays low until the transfer ends, so requests stall.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk_apb,
    input  logic                  i_rst_apb,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_resp_valid,
    output logic                  o_resp_err,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic [DATA_WIDTH-1:0] i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_wait_cnt;
    logic                  r_ready;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic [CW-1:0]         w_wait_inc;
    logic                  w_timeout;
    logic                  w_accept;

    assign w_wait_inc = r_wait_cnt + CW'(1);
    // Abort fires on the wait cycle that brings the count up to the limit.
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_wait_inc == TO_LIMIT);
    assign w_accept   = i_valid && r_ready && (r_state == S_IDLE);

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_data    <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_paddr   <= i_addr;
                        r_pwdata  <= i_wr_data;
                        r_pwrite  <= i_rd0_wr1;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_ready   <= 1'b0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (i_pready) begin
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_ready      <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= i_pslverr;
                        r_rd_data    <= r_pwrite ? '0 : i_prdata;
                        r_state      <= S_IDLE;
                    end else if (w_timeout) begin
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_ready      <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_rd_data    <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_rd_data    = r_rd_data;
    assign o_psel       = r_psel;
    assign o_penable    = r_penable;
    assign o_pwrite     = r_pwrite;
    assign o_paddr      = r_paddr;
    assign o_pwdata     = r_pwdata;

endmodule
